// File: rtl/acc_pkg.sv
// acc_pkg: shared widths, FSM state type and beat slicing helper for the adder-tree accumulator
package acc_pkg;
  localparam int DW = 32;
  localparam int NUM_IN = 16;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic logic [DW-1:0] in_slice(input logic [NUM_IN*DW-1:0] d, input int k);
    return d[k*DW +: DW];
  endfunction
endpackage

// File: rtl/adder_tree_8.sv
// adder_tree_8: combinational 16-input balanced adder tree, result modulo 2^32
module adder_tree_8
  import acc_pkg::*;
(
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] a2,
  input  logic [DW-1:0] a3,
  input  logic [DW-1:0] a4,
  input  logic [DW-1:0] a5,
  input  logic [DW-1:0] a6,
  input  logic [DW-1:0] a7,
  input  logic [DW-1:0] a8,
  input  logic [DW-1:0] a9,
  input  logic [DW-1:0] a10,
  input  logic [DW-1:0] a11,
  input  logic [DW-1:0] a12,
  input  logic [DW-1:0] a13,
  input  logic [DW-1:0] a14,
  input  logic [DW-1:0] a15,
  output logic [DW-1:0] sum
);
  logic [DW-1:0] l0, l1, l2, l3, l4, l5, l6, l7, m0, m1, m2, m3, n0, n1;
  assign l0 = a0 + a1;
  assign l1 = a2 + a3;
  assign l2 = a4 + a5;
  assign l3 = a6 + a7;
  assign l4 = a8 + a9;
  assign l5 = a10 + a11;
  assign l6 = a12 + a13;
  assign l7 = a14 + a15;
  assign m0 = l0 + l1;
  assign m1 = l2 + l3;
  assign m2 = l4 + l5;
  assign m3 = l6 + l7;
  assign n0 = m0 + m1;
  assign n1 = m2 + m3;
  assign sum = n0 + n1;
endmodule

// File: rtl/adder_tree_acc_ctrl.sv
// adder_tree_acc_ctrl: sequences programmed beats through adder_tree_8 and accumulates a 32-bit total
module adder_tree_acc_ctrl
  import acc_pkg::*;
#(
  parameter int LEN_W = 8
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_IN*DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_sum,
  output logic                 out_ovf
);
  state_t state;
  logic [LEN_W-1:0] len, beat_cnt;
  logic [DW-1:0] tree_sum, ps_q, acc, acc_n;
  logic ps_v, ps_last, acc_c, accept;
  adder_tree_8 u_tree (
    .a0(in_slice(in_data, 0)),
    .a1(in_slice(in_data, 1)),
    .a2(in_slice(in_data, 2)),
    .a3(in_slice(in_data, 3)),
    .a4(in_slice(in_data, 4)),
    .a5(in_slice(in_data, 5)),
    .a6(in_slice(in_data, 6)),
    .a7(in_slice(in_data, 7)),
    .a8(in_slice(in_data, 8)),
    .a9(in_slice(in_data, 9)),
    .a10(in_slice(in_data, 10)),
    .a11(in_slice(in_data, 11)),
    .a12(in_slice(in_data, 12)),
    .a13(in_slice(in_data, 13)),
    .a14(in_slice(in_data, 14)),
    .a15(in_slice(in_data, 15)),
    .sum(tree_sum)
  );
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign in_ready = state == ACC && beat_cnt < len;
  assign accept = in_valid && in_ready;
  assign {acc_c, acc_n} = {1'b0, acc} + {1'b0, ps_q};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      beat_cnt <= '0;
      acc <= '0;
      ps_q <= '0;
      ps_v <= 1'b0;
      ps_last <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      ps_v <= accept;
      if (accept) begin
        ps_q <= tree_sum;
        ps_last <= beat_cnt == len - LEN_W'(1);
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (ps_v) begin
        acc <= acc_n;
        out_ovf <= out_ovf | acc_c;
        if (ps_last) begin
          out_sum <= acc_n;
          state <= DONE;
        end
      end
      if (state == IDLE && start) begin
        len <= cfg_len;
        beat_cnt <= '0;
        acc <= '0;
        out_sum <= '0;
        out_ovf <= 1'b0;
        state <= cfg_len == '0 ? DONE : ACC;
      end
      if (state == DONE && out_ready) state <= IDLE;
    end
endmodule
